// File: rtl/jcpu_pkg.sv
// Shared constants and state type for the instruction stepper.
// Phase encoding matches the sub-step order of the old dual-edge clock pair.
package jcpu_pkg;

  localparam int PHASES = 4;

  localparam logic [1:0] PH_E0   = 2'd0;
  localparam logic [1:0] PH_S    = 2'd1;
  localparam logic [1:0] PH_E2   = 2'd2;
  localparam logic [1:0] PH_IDLE = 2'd3;

  typedef enum logic {
    PREROLL = 1'b0,
    RUN     = 1'b1
  } state_t;

endpackage

// File: rtl/jphase_gen.sv
// Sub-step phase counter with registered enable/set strobes.
// Strobes are computed from the next phase so they change together with phase.
module jphase_gen
  import jcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] phase,
  output logic       clke,
  output logic       clks,
  output logic       wrap_en
);

  logic [1:0] phase_next;

  always_comb begin
    phase_next = phase;
    if (en) phase_next = phase + 2'd1;
  end

  // Reset parks in the idle phase so the first enabled cycle lands on phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_IDLE;
      clke  <= 1'b0;
      clks  <= 1'b0;
    end else begin
      phase <= phase_next;
      clke  <= (phase_next != PH_IDLE);
      clks  <= (phase_next == PH_S);
    end
  end

  assign wrap_en = en && (phase == PH_IDLE);

endmodule

// File: rtl/jstepper_seq.sv
// Instruction stepper: step index/one-hot, instruction boundary pulse and counter.
// Single rising-edge clock; phase generation is delegated to jphase_gen.
module jstepper_seq
  import jcpu_pkg::*;
#(
  parameter  int STEPS = 7,
  parameter  int CNT_W = 16,
  localparam int IDX_W = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             end_early,
  output logic [STEPS-1:0] step_oh,
  output logic [IDX_W-1:0] step_idx,
  output logic [1:0]       phase,
  output logic             clke,
  output logic             clks,
  output logic             instr_done,
  output logic [CNT_W-1:0] icount
);

  localparam logic [STEPS-1:0] OH_ONE   = STEPS'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEPS - 1);

  state_t           state, state_next;
  logic             wrap_en;
  logic             wrap;
  logic [IDX_W-1:0] idx_next;

  jphase_gen u_phase (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .phase   (phase),
    .clke    (clke),
    .clks    (clks),
    .wrap_en (wrap_en)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= PREROLL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PREROLL: if (en) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = PREROLL;
    endcase
  end

  // Pre-roll also sits in the idle phase, so wrap_en must be qualified by RUN.
  assign wrap = wrap_en && (state == RUN) && ((step_idx == IDX_LAST) || end_early);

  always_comb begin
    idx_next = step_idx;
    if (state == PREROLL || wrap)  idx_next = '0;
    else if (wrap_en)              idx_next = step_idx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_idx <= '0;
      step_oh  <= '0;
    end else if (en) begin
      step_idx <= idx_next;
      step_oh  <= OH_ONE << idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_done <= 1'b0;
      icount     <= '0;
    end else begin
      instr_done <= wrap;
      if (wrap) icount <= icount + CNT_W'(1);
    end
  end

endmodule
